pp_accum: RTL and testbench
===========================

# pp_accum

Partial-product accumulator that sits directly downstream of the shift-and-add multiplier. It consumes the signed 16-bit partial-product stream and sums it into full products. Products are summed across a programmable vector length to form a dot-product result. Each result goes out through a one-entry valid/ready output register, and the block back-pressures upstream when that register cannot drain.

## Interface
Parameters:
- `ACC_W`, 24, accumulator and result width; must be ≥ 16.
- `CNT_W`, 8, width of the vector-length and product counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `vec_len`  in  CNT_W  number of products per result. Sampled on the first accepted event of a vector. Value 0 is treated as 1.
- `pp_vld`  in  1  `pp_data` is a valid partial product.
- `pp_data`  in  16  signed partial product (two's complement).
- `prod_done`  in  1  one-cycle pulse marking the end of the current product.
- `in_rdy`  out  1  block can accept `pp_vld`/`prod_done` this cycle.
- `res_vld`  out  1  result register holds a valid result.
- `res_data`  out  ACC_W  signed dot-product result.
- `res_ovf`  out  1  signed overflow occurred while accumulating this result.
- `res_rdy`  in  1  downstream accepts the result when `res_vld & res_rdy`.
- `prod_cnt`  out  CNT_W  products completed in the current vector.

## Operation
- **Reset:** state=ACC; acc, `prod_cnt`, `res_data` are 0; `res_vld`, `res_ovf`, ovf_sticky are 0; `in_rdy`=1.
- **Accepted events:**
  - `pp_vld` and `prod_done` count only when `in_rdy`=1.
  - Upstream must not present events while `in_rdy`=0; events presented then are ignored.
- **Accumulation:**
  - On `pp_vld`: acc <= acc + sext(`pp_data`, ACC_W). Arithmetic wraps.
  - ovf_sticky is set when both operands have the same sign and the sum's sign differs from them.
- **Product end:**
  - On `prod_done`, `prod_cnt` increments.
  - `pp_vld` and `prod_done` in the same cycle: the partial product belongs to the product being closed.
  - `prod_done` with no preceding partial product is a zero product. It counts toward `vec_len` and adds nothing.
- **vec_len latch:** captured when `prod_cnt`==0 and the vector's first accepted event occurs.
- **Vector completion:** `prod_done` with `prod_cnt`+1 == latched length.
  - The final sum includes any same-cycle `pp_data`.
  - If the result register is free (`res_vld`=0), or is draining this cycle (`res_vld & res_rdy`):
    - Load `res_data` and `res_ovf` next cycle.
    - Clear acc, `prod_cnt` and ovf_sticky to 0.
    - Stay in ACC.
  - Otherwise go to STALL. acc, `prod_cnt` and ovf_sticky hold the completed vector.
- **STALL:**
  - `in_rdy`=0.
  - On `res_rdy`: load the held sum into the result register, clear acc/`prod_cnt`/ovf_sticky, and return to ACC next cycle.
- **Result register:**
  - `res_vld` clears on handshake unless a new result loads the same cycle.
  - `res_data` and `res_ovf` are stable while `res_vld & ~res_rdy`.
- **Reset mid-operation:** all state returns to reset values immediately. A partial vector and a pending result are discarded.

## Timing
- Latency from the completing `prod_done` edge to `res_vld`=1 is 1 cycle (ACC path).
- In ACC the block accepts one partial product per cycle with no bubbles. `vec_len`=1 yields one result per product.
- Back-to-back results: with `res_rdy` held 1, a result can load every cycle.
- STALL entry:
  - `in_rdy` drops the cycle after the completing `prod_done`.
  - `in_rdy` rises the cycle after the `res_rdy` handshake.
  - Minimum STALL duration is 1 cycle.
- `in_rdy` is registered; it has no combinational path from `res_rdy`.
- `prod_cnt` wraps never. A completion always resets it, so `prod_cnt` < max(latched length, 1).

## Test plan
- **Single product:** reset, then `vec_len`=1; pp 0x0005 then pp 0x0014 with `prod_done` on the same cycle; `res_rdy`=1 -> `res_data`=25, `res_vld`=1 for exactly 1 cycle, `res_ovf`=0, `prod_cnt`=0.
- **Dot product with negative and zero products:**
  - Stimulus: `vec_len`=3; products 7×3 (pp 0x0007, 0x000E), 0 (bare `prod_done`), and −2×4 (pp 0xFFF8).
  - Required: `res_data`=13, asserted 1 cycle after the third `prod_done`.
- **Back-pressure:**
  - Stimulus: `res_rdy`=0 with `vec_len`=1; send product 4, then product 6.
  - Required: first result holds 4; `in_rdy`=0 the cycle after the second `prod_done`.
  - Then raise `res_rdy` -> 4 accepted, next cycle `res_data`=6, `in_rdy`=1.
- **Overflow:**
  - Stimulus: ACC_W=16, `vec_len`=2; pp 0x7FFF with `prod_done`, then pp 0x0001 with `prod_done`.
  - Required: `res_data`=0x8000, `res_ovf`=1. The next vector reports `res_ovf`=0.
- **vec_len=0:** each `prod_done` produces a result, the same as `vec_len`=1.
- **Reset mid-vector:**
  - Stimulus: assert `rst` asynchronously after 2 of 3 products, and again while in STALL.
  - Required: all outputs return to reset values without a clock edge. A fresh vector then yields the correct sum with no residue.

Source files
------------

// File: rtl/pp_accum.sv
// Partial-product accumulator: sums signed partial products into products, and
// products into dot-product results. Each result goes out through a one-entry
// valid/ready register, and the block stalls upstream while that register is full.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_ACC   | accepting partial products and product-end pulses (in_rdy=1)
// ST_STALL | completed vector held, waiting for the result register to drain
module pp_accum #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] vec_len,
    input  logic             pp_vld,
    input  logic [15:0]      pp_data,
    input  logic             prod_done,
    output logic             in_rdy,
    output logic             res_vld,
    output logic [ACC_W-1:0] res_data,
    output logic             res_ovf,
    input  logic             res_rdy,
    output logic [CNT_W-1:0] prod_cnt
);

    typedef enum logic {ST_ACC, ST_STALL} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;
    logic               started_q, started_d;
    logic [ACC_W-1:0]   res_data_q, res_data_d;
    logic               res_ovf_q, res_ovf_d;
    logic               res_vld_q, res_vld_d;

    logic [ACC_W-1:0]   pp_ext;
    logic [ACC_W-1:0]   sum;
    logic               add_ovf;
    logic [CNT_W-1:0]   len_in;
    logic [CNT_W-1:0]   len_cur;
    logic               last;
    logic               res_free;

    always_comb begin
        pp_ext   = ACC_W'(signed'(pp_data));
        sum      = pp_vld ? acc_q + pp_ext : acc_q;
        add_ovf  = pp_vld && (acc_q[ACC_W-1] == pp_ext[ACC_W-1])
                          && (sum[ACC_W-1] != acc_q[ACC_W-1]);
        len_in   = (vec_len == '0) ? CNT_W'(1) : vec_len;
        // The first event of a vector uses the live vec_len; later ones the latched copy.
        len_cur  = started_q ? len_q : len_in;
        last     = prod_done && (({1'b0, cnt_q} + (CNT_W+1)'(1)) == {1'b0, len_cur});
        res_free = !res_vld_q || res_rdy;
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        ovf_d      = ovf_q;
        started_d  = started_q;
        res_data_d = res_data_q;
        res_ovf_d  = res_ovf_q;
        res_vld_d  = res_vld_q;

        if (res_vld_q && res_rdy) begin
            res_vld_d = 1'b0;
        end

        case (state_q)
            ST_ACC: begin
                if (pp_vld || prod_done) begin
                    started_d = 1'b1;
                    if (!started_q) begin
                        len_d = len_in;
                    end
                    acc_d = sum;
                    ovf_d = ovf_q | add_ovf;
                    if (prod_done) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (last) begin
                        if (res_free) begin
                            res_data_d = sum;
                            res_ovf_d  = ovf_q | add_ovf;
                            res_vld_d  = 1'b1;
                            acc_d      = '0;
                            cnt_d      = '0;
                            ovf_d      = 1'b0;
                            started_d  = 1'b0;
                        end else begin
                            state_d = ST_STALL;
                        end
                    end
                end
            end
            ST_STALL: begin
                if (res_rdy) begin
                    res_data_d = acc_q;
                    res_ovf_d  = ovf_q;
                    res_vld_d  = 1'b1;
                    acc_d      = '0;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                    started_d  = 1'b0;
                    state_d    = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            ovf_q      <= 1'b0;
            started_q  <= 1'b0;
            res_data_q <= '0;
            res_ovf_q  <= 1'b0;
            res_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            ovf_q      <= ovf_d;
            started_q  <= started_d;
            res_data_q <= res_data_d;
            res_ovf_q  <= res_ovf_d;
            res_vld_q  <= res_vld_d;
        end
    end

    assign in_rdy   = (state_q == ST_ACC);
    assign res_vld  = res_vld_q;
    assign res_data = res_data_q;
    assign res_ovf  = res_ovf_q;
    assign prod_cnt = cnt_q;

endmodule

// File: tb/tb_pp_accum.sv
// Directed bench for pp_accum: a 24-bit and a 16-bit instance share one input
// stream so the 16-bit copy can show accumulator overflow.
module tb_pp_accum;

    logic        clk;
    logic        rst;
    logic [7:0]  vec_len;
    logic        pp_vld;
    logic [15:0] pp_data;
    logic        prod_done;
    logic        res_rdy;

    logic        in_rdy, res_vld, res_ovf;
    logic [23:0] res_data;
    logic [7:0]  prod_cnt;

    logic        in_rdy16, res_vld16, res_ovf16;
    logic [15:0] res_data16;
    logic [7:0]  prod_cnt16;

    int checks = 0;
    int errors = 0;

    pp_accum #(.ACC_W(24), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .vec_len(vec_len), .pp_vld(pp_vld), .pp_data(pp_data),
        .prod_done(prod_done), .in_rdy(in_rdy), .res_vld(res_vld), .res_data(res_data),
        .res_ovf(res_ovf), .res_rdy(res_rdy), .prod_cnt(prod_cnt)
    );

    pp_accum #(.ACC_W(16), .CNT_W(8)) dut16 (
        .clk(clk), .rst(rst), .vec_len(vec_len), .pp_vld(pp_vld), .pp_data(pp_data),
        .prod_done(prod_done), .in_rdy(in_rdy16), .res_vld(res_vld16), .res_data(res_data16),
        .res_ovf(res_ovf16), .res_rdy(res_rdy), .prod_cnt(prod_cnt16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic pv, input logic [15:0] d, input logic pd, input logic rr);
        pp_vld    = pv;
        pp_data   = d;
        prod_done = pd;
        res_rdy   = rr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; vec_len = 8'd1; pp_vld = 1'b0; pp_data = 16'h0;
        prod_done = 1'b0; res_rdy = 1'b1;
        #12;
        chk("rst_in_rdy",   32'(in_rdy),   32'd1);
        chk("rst_res_vld",  32'(res_vld),  32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_prod_cnt", 32'(prod_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single product 5 + 20
        vec_len = 8'd1;
        cyc(1'b1, 16'h0005, 1'b0, 1'b1);
        chk("single_no_res", 32'(res_vld), 32'd0);
        cyc(1'b1, 16'h0014, 1'b1, 1'b1);
        chk("single_vld",  32'(res_vld),  32'd1);
        chk("single_data", 32'(res_data), 32'd25);
        chk("single_ovf",  32'(res_ovf),  32'd0);
        chk("single_cnt",  32'(prod_cnt), 32'd0);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("single_vld_1cyc", 32'(res_vld), 32'd0);

        // dot product 21 + 0 - 8; vec_len changes after the latch point
        vec_len = 8'd3;
        cyc(1'b1, 16'h0007, 1'b0, 1'b1);
        vec_len = 8'd5;
        cyc(1'b1, 16'h000E, 1'b1, 1'b1);
        chk("dot_cnt1", 32'(prod_cnt), 32'd1);
        cyc(1'b0, 16'h0, 1'b1, 1'b1);
        chk("dot_cnt2", 32'(prod_cnt), 32'd2);
        chk("dot_no_res", 32'(res_vld), 32'd0);
        cyc(1'b1, 16'hFFF8, 1'b1, 1'b1);
        chk("dot_vld",  32'(res_vld),  32'd1);
        chk("dot_data", 32'(res_data), 32'd13);
        chk("dot_cnt0", 32'(prod_cnt), 32'd0);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);

        // back-pressure: 4 held, 6 stalls, event during stall ignored
        vec_len = 8'd1;
        cyc(1'b1, 16'h0004, 1'b1, 1'b0);
        chk("bp_first_data", 32'(res_data), 32'd4);
        chk("bp_in_rdy_acc", 32'(in_rdy),   32'd1);
        cyc(1'b1, 16'h0006, 1'b1, 1'b0);
        chk("bp_stall_in_rdy", 32'(in_rdy),   32'd0);
        chk("bp_hold_data",    32'(res_data), 32'd4);
        chk("bp_hold_vld",     32'(res_vld),  32'd1);
        cyc(1'b1, 16'h0064, 1'b1, 1'b0);
        chk("bp_stall_hold", 32'(res_data), 32'd4);
        chk("bp_stall_rdy",  32'(in_rdy),   32'd0);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("bp_second_data", 32'(res_data), 32'd6);
        chk("bp_second_vld",  32'(res_vld),  32'd1);
        chk("bp_in_rdy_back", 32'(in_rdy),   32'd1);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("bp_drained", 32'(res_vld), 32'd0);

        // overflow in the 16-bit copy only
        vec_len = 8'd2;
        cyc(1'b1, 16'h7FFF, 1'b1, 1'b1);
        cyc(1'b1, 16'h0001, 1'b1, 1'b1);
        chk("ovf16_data", 32'(res_data16), 32'h8000);
        chk("ovf16_flag", 32'(res_ovf16),  32'd1);
        chk("ovf24_data", 32'(res_data),   32'h8000);
        chk("ovf24_flag", 32'(res_ovf),    32'd0);
        cyc(1'b1, 16'h0003, 1'b1, 1'b1);
        cyc(1'b1, 16'hFFFF, 1'b1, 1'b1);
        chk("ovf16_next_data", 32'(res_data16), 32'd2);
        chk("ovf16_next_flag", 32'(res_ovf16),  32'd0);

        // vec_len = 0 behaves as 1
        vec_len = 8'd0;
        cyc(1'b1, 16'h0009, 1'b1, 1'b1);
        chk("len0_first", 32'(res_data), 32'd9);
        chk("len0_vld",   32'(res_vld),  32'd1);
        cyc(1'b1, 16'hFFFD, 1'b1, 1'b1);
        chk("len0_second", 32'(res_data), 32'hFFFFFD);
        chk("len0_cnt",    32'(prod_cnt), 32'd0);

        // async reset after 2 of 3 products
        vec_len = 8'd3;
        cyc(1'b1, 16'h000A, 1'b1, 1'b1);
        cyc(1'b1, 16'h0014, 1'b1, 1'b1);
        chk("mid_cnt_pre", 32'(prod_cnt), 32'd2);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_cnt",  32'(prod_cnt), 32'd0);
        chk("mid_rst_data", 32'(res_data), 32'd0);
        chk("mid_rst_vld",  32'(res_vld),  32'd0);
        #2 rst = 1'b0;
        cyc(1'b1, 16'h0001, 1'b1, 1'b1);
        cyc(1'b1, 16'h0002, 1'b1, 1'b1);
        chk("fresh_no_res", 32'(res_vld), 32'd0);
        cyc(1'b1, 16'h0003, 1'b1, 1'b1);
        chk("fresh_data", 32'(res_data), 32'd6);
        chk("fresh_vld",  32'(res_vld),  32'd1);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);

        // async reset while stalled
        vec_len = 8'd1;
        cyc(1'b1, 16'h0004, 1'b1, 1'b0);
        cyc(1'b1, 16'h0005, 1'b1, 1'b0);
        chk("stall_pre_rdy", 32'(in_rdy), 32'd0);
        #3 rst = 1'b1;
        #1;
        chk("stall_rst_rdy",  32'(in_rdy),   32'd1);
        chk("stall_rst_vld",  32'(res_vld),  32'd0);
        chk("stall_rst_data", 32'(res_data), 32'd0);
        #2 rst = 1'b0;
        cyc(1'b1, 16'h0007, 1'b1, 1'b1);
        chk("post_stall_data", 32'(res_data), 32'd7);
        chk("post_stall_vld",  32'(res_vld),  32'd1);
        cyc(1'b0, 16'h0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
